// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 INTA responder: FSM encoding,
// default pulse/gap lengths and the phase counter width.
package pic_pkg;

  localparam int PULSE_CYCLES_DEF = 2;
  localparam int GAP_CYCLES_DEF   = 1;
  localparam int INTA_CNT_W       = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    PRESENT
  } inta_state_t;

  // INTA_N is driven low only while acknowledging.
  function automatic logic is_ack_state(inta_state_t s);
    return (s == ACK1) || (s == ACK2);
  endfunction

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer bringing the PIC INT line into the CLK domain;
// both flops clear on synchronous RST.
module int_sync (
  input  logic CLK,
  input  logic RST,
  input  logic i_async,
  output logic o_sync
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
    end
  end

  assign o_sync = r_s2;

endmodule

// File: rtl/int_ack_sequencer.sv
// CPU-side 8259 responder: runs the two-pulse INTA cycle, captures the vector
// and offers it over valid/ready. Optional feature macro: INTA_SPURIOUS_EN.
module int_ack_sequencer
  import pic_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INT,
  input  logic       IE,
  input  logic [7:0] DATA,
  output logic       INTA_N,
  output logic       BUSY,
  output logic [7:0] VEC,
  output logic       VEC_VALID,
  input  logic       VEC_READY,
  output logic       SPURIOUS
);

  localparam logic [INTA_CNT_W-1:0] PULSE_LOAD = INTA_CNT_W'(PULSE_CYCLES);
  localparam logic [INTA_CNT_W-1:0] GAP_LOAD   = INTA_CNT_W'(GAP_CYCLES);
  localparam logic [INTA_CNT_W-1:0] CNT_ONE    = INTA_CNT_W'(1);

  logic                  w_s2;
  inta_state_t           r_state;
  inta_state_t           w_state_next;
  logic [INTA_CNT_W-1:0] r_cnt;
  logic [INTA_CNT_W-1:0] w_cnt_next;
  logic                  w_cnt_last;
  logic                  w_capture;
  logic                  w_busy;
  logic                  w_vec_valid;
  logic                  w_inta_n_next;
  logic                  r_inta_n;
  logic [7:0]            r_vec;

  int_sync u_int_sync (
    .CLK     (CLK),
    .RST     (RST),
    .i_async (INT),
    .o_sync  (w_s2)
  );

  assign w_cnt_last = (r_cnt == CNT_ONE);

  // State register; INTA_N is registered from the next state so it tracks
  // the registered state exactly with no combinational glitching.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_inta_n <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_inta_n <= w_inta_n_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_s2 && IE) begin
          w_state_next = ACK1;
          w_cnt_next   = PULSE_LOAD;
        end
      end
      ACK1: begin
        if (w_cnt_last) begin
          w_state_next = GAP;
          w_cnt_next   = GAP_LOAD;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (w_cnt_last) begin
          w_state_next = ACK2;
          w_cnt_next   = PULSE_LOAD;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      ACK2: begin
        if (w_cnt_last) begin
          w_state_next = PRESENT;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      PRESENT: begin
        if (VEC_READY) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_busy        = (r_state != IDLE);
    w_vec_valid   = (r_state == PRESENT);
    w_inta_n_next = ~is_ack_state(w_state_next);
    w_capture     = (r_state == ACK2) && w_cnt_last;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vec <= 8'h00;
    end else if (w_capture) begin
      r_vec <= DATA;
    end
  end

`ifdef INTA_SPURIOUS_EN
  logic r_spur_flag;
  logic r_spurious;

  // INT already gone by the end of ACK1 marks the request as spurious.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_spur_flag <= 1'b0;
      r_spurious  <= 1'b0;
    end else begin
      if ((r_state == ACK1) && w_cnt_last) begin
        r_spur_flag <= w_s2;
      end
      if (w_capture) begin
        r_spurious <= ~r_spur_flag;
      end
    end
  end

  assign SPURIOUS = r_spurious;
`else
  assign SPURIOUS = 1'b0;
`endif

  assign INTA_N    = r_inta_n;
  assign BUSY      = w_busy;
  assign VEC       = r_vec;
  assign VEC_VALID = w_vec_valid;

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Directed bench for int_ack_sequencer: default timing, IE gating, ready
// backpressure, mid-sequence reset, spurious qualification and P=1/G=3 timing.
module tb_int_ack_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       intr;
  logic       ie;
  logic       vec_ready;
  logic [7:0] data;
  logic       inta_n, busy, vec_valid, spurious;
  logic [7:0] vec;

  logic       b_int;
  logic       b_inta_n, b_busy, b_vec_valid, b_spurious;
  logic [7:0] b_vec;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  int_ack_sequencer dut (
    .CLK       (clk),
    .RST       (rst),
    .INT       (intr),
    .IE        (ie),
    .DATA      (data),
    .INTA_N    (inta_n),
    .BUSY      (busy),
    .VEC       (vec),
    .VEC_VALID (vec_valid),
    .VEC_READY (vec_ready),
    .SPURIOUS  (spurious)
  );

  int_ack_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(3)) dut_b (
    .CLK       (clk),
    .RST       (rst),
    .INT       (b_int),
    .IE        (ie),
    .DATA      (data),
    .INTA_N    (b_inta_n),
    .BUSY      (b_busy),
    .VEC       (b_vec),
    .VEC_VALID (b_vec_valid),
    .VEC_READY (vec_ready),
    .SPURIOUS  (b_spurious)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Entered on the falling edge before E0 with INT=1, IE=1, VEC_READY=1.
  task automatic run_seq(input logic [7:0] exp_vec, input string name);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("%s_inta_n_E%0d", name, k), inta_n,
          (k == 2 || k == 3 || k == 5 || k == 6) ? 8'd0 : 8'd1);
      chk($sformatf("%s_busy_E%0d", name, k), busy, (k >= 2) ? 8'd1 : 8'd0);
      chk($sformatf("%s_valid_E%0d", name, k), vec_valid, (k == 7) ? 8'd1 : 8'd0);
    end
    chk({name, "_vec"}, vec, exp_vec);
    chk({name, "_spurious"}, spurious, 8'd0);
    intr = 1'b0;
    ie   = 1'b0;
    step();
    chk({name, "_valid_fall"}, vec_valid, 8'd0);
    chk({name, "_busy_idle"}, busy, 8'd0);
    $display("TXN %s vec=%02h", name, vec);
    step();
    step();
    chk({name, "_no_restart"}, busy, 8'd0);
  endtask

  initial begin
    rst       = 1'b1;
    intr      = 1'b0;
    b_int     = 1'b0;
    ie        = 1'b0;
    vec_ready = 1'b1;
    data      = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_inta_n", inta_n, 8'd1);
    chk("rst_busy", busy, 8'd0);
    chk("rst_vec", vec, 8'h00);
    chk("rst_valid", vec_valid, 8'd0);
    chk("rst_spurious", spurious, 8'd0);
    chk("rst_b_inta_n", b_inta_n, 8'd1);

    // Default timing, vector 0A
    ie   = 1'b1;
    data = 8'h0A;
    intr = 1'b1;
    run_seq(8'h0A, "basic");

    // IE gating: INT high for 20 clocks with IE low
    intr = 1'b1;
    ie   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ie_off_inta_n", inta_n, 8'd1);
      chk("ie_off_busy", busy, 8'd0);
    end
    ie        = 1'b1;
    data      = 8'h33;
    vec_ready = 1'b0;
    step();
    chk("ie_on_inta_n", inta_n, 8'd0);
    chk("ie_on_busy", busy, 8'd1);
    intr = 1'b0;
    repeat (5) step();
    chk("bp_valid_rise", vec_valid, 8'd1);
    chk("bp_vec", vec, 8'h33);
    data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_hold", vec_valid, 8'd1);
      chk("bp_vec_hold", vec, 8'h33);
      chk("bp_inta_n_hold", inta_n, 8'd1);
    end
    vec_ready = 1'b1;
    step();
    chk("bp_valid_fall", vec_valid, 8'd0);
    chk("bp_busy_idle", busy, 8'd0);
    $display("TXN backpressure vec=%02h", vec);

    // Reset during GAP
    data = 8'h5C;
    intr = 1'b1;
    repeat (5) step();
    chk("gap_inta_n", inta_n, 8'd1);
    chk("gap_busy", busy, 8'd1);
    rst = 1'b1;
    step();
    chk("midrst_inta_n", inta_n, 8'd1);
    chk("midrst_busy", busy, 8'd0);
    chk("midrst_valid", vec_valid, 8'd0);
    chk("midrst_vec", vec, 8'h00);
    rst = 1'b0;
    run_seq(8'h5C, "after_rst");

    // Short INT pulse (sampled at E0 and E1 only), vector 0F
    ie   = 1'b1;
    data = 8'h0F;
    intr = 1'b1;
    step();
    step();
    intr = 1'b0;
    repeat (6) step();
    chk("short_valid", vec_valid, 8'd1);
    chk("short_vec", vec, 8'h0F);
`ifdef INTA_SPURIOUS_EN
    chk("short_spurious", spurious, 8'd1);
`else
    chk("short_spurious", spurious, 8'd0);
`endif
    $display("TXN short_int vec=%02h spurious=%0d", vec, spurious);
    step();
    chk("short_valid_fall", vec_valid, 8'd0);

    // PULSE_CYCLES=1, GAP_CYCLES=3 instance
    b_int = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("pg_inta_n_E%0d", k), b_inta_n,
          (k == 2 || k == 6) ? 8'd0 : 8'd1);
      chk($sformatf("pg_valid_E%0d", k), b_vec_valid, (k == 7) ? 8'd1 : 8'd0);
    end
    chk("pg_vec", b_vec, 8'h0F);
    chk("pg_main_idle", busy, 8'd0);
    b_int = 1'b0;
    ie    = 1'b0;
    step();
    chk("pg_valid_fall", b_vec_valid, 8'd0);
    chk("pg_busy_idle", b_busy, 8'd0);
    $display("TXN pulse1_gap3 vec=%02h", b_vec);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_ack_sequencer.md
# int_ack_sequencer

CPU-side responder for the 8259 interrupt line. It detects INT from the PIC and runs the two-pulse INTA bus cycle. It captures the vector byte the PIC drives onto DATA during the second pulse and hands the vector to the CPU core over a valid/ready handshake. It sits between the PIC top level and the core's exception/dispatch logic.

## Interface
- PULSE_CYCLES, 2: length of each INTA_N low phase in clocks; legal range 1..15.
- GAP_CYCLES, 1: INTA_N high time between the two pulses in clocks; legal range 1..15.

- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  reset, synchronous and active-high.
- INT  input  1  interrupt request from PIC; asynchronous to CLK and synchronized internally.
- IE  input  1  core interrupt-enable flag; a new sequence starts only while IE=1.
- DATA  input  8  PIC data bus; sampled only at the vector capture edge.
- INTA_N  output  1  interrupt acknowledge to PIC, active-low, registered.
- BUSY  output  1  high in every state except IDLE.
- VEC  output  8  captured vector; stable while VEC_VALID=1.
- VEC_VALID  output  1  vector available to core.
- VEC_READY  input  1  core accepts vector.
- SPURIOUS  output  1  qualifies VEC; meaningful only while VEC_VALID=1.

## Operation
- Synchronizer: INT passes through two flops (s1, s2). The FSM sees only s2.
- States and transitions:
  - IDLE: go to ACK1 when s2=1 and IE=1.
  - ACK1: INTA_N=0 for PULSE_CYCLES clocks, then go to GAP.
  - GAP: INTA_N=1 for GAP_CYCLES clocks, then go to ACK2.
  - ACK2: INTA_N=0 for PULSE_CYCLES clocks. On the edge that leaves ACK2, capture VEC<=DATA and go to PRESENT.
  - PRESENT: hold VEC_VALID=1. Go to IDLE on the first edge with VEC_READY=1.
- A single down-counter, 4 bits wide, is loaded on entry to ACK1, GAP and ACK2. The state advances on the edge where the counter equals 1.
- INTA_N is registered. It is low exactly when the registered state is ACK1 or ACK2.
- Once a sequence starts, IE and INT changes have no effect on it. A sequence is never aborted except by RST.
- VEC_READY is ignored outside PRESENT.
- Back-to-back: IDLE re-evaluates s2/IE on the edge after PRESENT exits. The minimum IDLE dwell is 1 clock.
- Reset values: INTA_N=1, BUSY=0, VEC=8'h00, VEC_VALID=0, SPURIOUS=0; state IDLE, counter 0, s1=s2=0.
- RST mid-sequence: INTA_N returns to 1 at that edge, and any partial vector is discarded.

## Timing
- Let E0 be the first edge that samples INT=1. s2 goes high after E1. The FSM leaves IDLE at E2, so INTA_N falls after E2.
- With P=PULSE_CYCLES and G=GAP_CYCLES:
  - INTA_N is low over (E2, E2+P].
  - INTA_N is high over (E2+P, E2+P+G].
  - INTA_N is low over (E2+P+G, E2+2P+G].
  - DATA is sampled at edge E2+2P+G, and VEC_VALID rises after that edge.
- INT-to-VEC_VALID latency is 2P+G+2 edges after E0. With defaults this is 7 edges.
- Handshake: a transfer occurs on an edge with VEC_VALID=1 and VEC_READY=1. VEC_VALID falls after that edge. If VEC_READY is held high, VEC_VALID is high for exactly 1 clock.

## Configuration
- INTA_SPURIOUS_EN defined:
  - At the last clock of ACK1, s2 is latched into spur_flag.
  - At capture, SPURIOUS<=~spur_flag. VEC still takes DATA; the PIC drives IR7 for spurious requests.
- INTA_SPURIOUS_EN undefined: SPURIOUS is tied to 0 and spur_flag does not exist.

## Structure
- Package pic_pkg:
  - FSM state enum (IDLE, ACK1, GAP, ACK2, PRESENT).
  - PULSE_CYCLES_DEF and GAP_CYCLES_DEF.
  - Counter width constant INTA_CNT_W=4.
- Sub-module int_sync: 2-flop synchronizer with synchronous RST clear. All other logic lives in int_ack_sequencer.

## Test plan
- Defaults, IE=1, DATA=8'h0A, INT high from E0, VEC_READY=1:
  - INTA_N is low over (E2,E4] and (E5,E7].
  - VEC=8'h0A and VEC_VALID=1 for one clock after E7.
- IE=0 with INT held high for 20 clocks: INTA_N stays 1 and BUSY stays 0. Raise IE and the sequence starts 1 edge later.
- VEC_READY=0 for 5 clocks after capture: VEC_VALID and VEC (8'h33) stay stable. VEC_READY=1 causes VEC_VALID to fall after that edge.
- RST asserted during GAP: INTA_N=1, BUSY=0 and VEC_VALID=0 after that edge. A subsequent INT gives a full normal sequence.
- INTA_SPURIOUS_EN defined, INT high only for E0..E1, DATA=8'h0F: SPURIOUS=1 and VEC=8'h0F. With INT held high through the sequence: SPURIOUS=0.
- PULSE_CYCLES=1, GAP_CYCLES=3: INTA_N low over (E2,E3] and (E6,E7], and VEC_VALID rises after E7.
